// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store front-end (mem_access_unit).
// Optional feature macro: MEM_ALIGN_CHK_EN (misalignment detection).
package mem_access_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } mau_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    // Word ops need addr[1:0]==0, half ops need addr[0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lsb);
        logic mis;
        case (op)
            LW, SW:      mis = (lsb != 2'b00);
            LH, LHU, SH: mis = lsb[0];
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational lane steering: merges store data into a base word and
// extracts/extends load data from it (little-endian lanes).
module mem_lane_mux
    import mem_access_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lsb_i,
    input  logic [31:0] base_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and half of the base word
    always_comb begin
        byte_sel = base_i[7:0];
        unique case (addr_lsb_i)
            2'd0: byte_sel = base_i[7:0];
            2'd1: byte_sel = base_i[15:8];
            2'd2: byte_sel = base_i[23:16];
            2'd3: byte_sel = base_i[31:24];
        endcase
        half_sel = addr_lsb_i[1] ? base_i[31:16] : base_i[15:0];
    end

    // Load extraction with sign/zero extension
    always_comb begin
        load_word_o = '0;
        case (op_i)
            LW:      load_word_o = base_i;
            LH:      load_word_o = {{16{half_sel[15]}}, half_sel};
            LHU:     load_word_o = {16'h0000, half_sel};
            LB:      load_word_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_word_o = {24'h000000, byte_sel};
            default: load_word_o = '0;
        endcase
    end

    // Store merge: replace only the addressed lane, keep the rest of the base word
    always_comb begin
        store_word_o = base_i;
        case (op_i)
            SW: store_word_o = wdata_i;
            SH: begin
                if (addr_lsb_i[1]) store_word_o[31:16] = wdata_i[15:0];
                else               store_word_o[15:0]  = wdata_i[15:0];
            end
            SB: begin
                unique case (addr_lsb_i)
                    2'd0: store_word_o[7:0]   = wdata_i[7:0];
                    2'd1: store_word_o[15:8]  = wdata_i[7:0];
                    2'd2: store_word_o[23:16] = wdata_i[7:0];
                    2'd3: store_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            default: store_word_o = base_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: turns byte/half/word CPU requests into word accesses,
// using read-modify-write for sub-word stores.
// Optional feature macro: MEM_ALIGN_CHK_EN (misaligned requests answered with resp_err).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  mem_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    mau_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misaligned_req;
    logic [31:0]       mux_base;
    logic [31:0]       store_word;
    logic [31:0]       load_word;

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned_req = is_misaligned(req_op, req_addr[1:0]);
`else
    assign misaligned_req = 1'b0;
`endif

    // In RD the live memory word feeds the mux; in WR the captured merge base does
    assign mux_base = (state_q == StRd) ? mem_rd : base_q;

    mem_lane_mux u_lane_mux (
        .op_i        (op_q),
        .addr_lsb_i  (addr_q[1:0]),
        .base_i      (mux_base),
        .wdata_i     (wdata_q),
        .store_word_o(store_word),
        .load_word_o (load_word)
    );

    // Next-state and datapath capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        base_d  = base_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (misaligned_req) begin
                        rdata_d = '0;
                        state_d = StResp;
                    end else if (req_op == SW) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (is_store(op_q)) begin
                    base_d  = mem_rd;
                    state_d = StWr;
                end else begin
                    rdata_d = load_word;
                    state_d = StResp;
                end
            end
            StWr: begin
                rdata_d = '0;
                state_d = StResp;
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= LW;
            addr_q  <= '0;
            wdata_q <= '0;
            base_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            base_q  <= base_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ALIGN_CHK_EN
    logic err_q, err_d;

    // Error flag is decided at accept and presented with the response
    always_comb begin
        err_d = err_q;
        if ((state_q == StIdle) && req_valid) err_d = misaligned_req;
    end

    // Error flag register
    always_ff @(posedge ref_clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    // Reset in WR must not let the write through
    assign mem_we     = (state_q == StWr) & ~reset;
    assign mem_a      = ((state_q == StRd) || (state_q == StWr)) ?
                        {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wd     = (state_q == StWr) ? store_word : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word-wide memory model.
// Honours MEM_ALIGN_CHK_EN for the misalignment scenario.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        ref_clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    mem_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem [0:63];
    logic        mem_in_range;

    mem_access_unit #(
        .ADDR_W(32)
    ) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    assign mem_in_range = (mem_a[31:8] == 24'h0) && (mem_a[1:0] == 2'b00);
    assign mem_rd = mem_in_range ? dmem[mem_a[7:2]] : 32'hDEAD_BEEF;

    always @(posedge ref_clk) begin
        if (mem_we && mem_in_range) dmem[mem_a[7:2]] <= mem_wd;
    end

    // Issue one request and observe it to completion
    task automatic do_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int we_cnt, output logic [31:0] wd_seen, output int we_cyc);
        int n;
        lat = -1; rdata = 'x; err = 1'bx; we_cnt = 0; wd_seen = 'x; we_cyc = -1;
        @(negedge ref_clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge ref_clk);
            n++;
        end
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge ref_clk);
            if (mem_we) begin
                we_cnt++;
                wd_seen = mem_wd;
                we_cyc  = cyc;
            end
            if (resp_valid) begin
                lat   = cyc;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge ref_clk);
        #1 reset = 1'b0;
        @(negedge ref_clk);
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b exp 0", resp_err); end
        checks++; if (mem_we !== 1'b0) begin errors++;
            $display("FAIL reset_we got %b exp 0", mem_we); end
        checks++; if (mem_a !== 32'h0) begin errors++;
            $display("FAIL reset_mem_a got %h exp 0", mem_a); end
        checks++; if (mem_wd !== 32'h0) begin errors++;
            $display("FAIL reset_mem_wd got %h exp 0", mem_wd); end
    endtask

    task automatic test_load_ext();
        int lat, wc, wcyc; logic [31:0] rd, wds; logic er;
        mem_op_t     ops [4] = '{LB, LBU, LH, LW};
        logic [31:0] adr [4] = '{32'h12, 32'h12, 32'h12, 32'h10};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h80FF_7F01};
        do_req(SW, 32'h10, 32'h80FF_7F01, lat, rd, er, wc, wds, wcyc);
        for (int i = 0; i < 4; i++) begin
            do_req(ops[i], adr[i], 32'h0, lat, rd, er, wc, wds, wcyc);
            checks++; if (rd !== exp[i]) begin errors++;
                $display("FAIL load_data[%0d] got %h exp %h", i, rd, exp[i]); end
            checks++; if (lat != 2) begin errors++;
                $display("FAIL load_latency[%0d] got %0d exp 2", i, lat); end
        end
        @(negedge ref_clk);
        checks++; if (resp_rdata !== 32'h80FF_7F01) begin errors++;
            $display("FAIL load_hold got %h exp 80ff7f01", resp_rdata); end
    endtask

    task automatic test_sb_rmw();
        int lat, wc, wcyc; logic [31:0] rd, wds; logic er;
        do_req(SW, 32'h10, 32'h1122_3344, lat, rd, er, wc, wds, wcyc);
        do_req(SB, 32'h13, 32'h0000_00AB, lat, rd, er, wc, wds, wcyc);
        checks++; if (wc != 1) begin errors++;
            $display("FAIL sb_we_count got %0d exp 1", wc); end
        checks++; if (wds !== 32'hAB22_3344) begin errors++;
            $display("FAIL sb_wd got %h exp ab223344", wds); end
        checks++; if (wcyc != 2) begin errors++;
            $display("FAIL sb_we_cycle got %0d exp 2", wcyc); end
        checks++; if (lat != 3) begin errors++;
            $display("FAIL sb_latency got %0d exp 3", lat); end
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL sb_rdata got %h exp 0", rd); end
        checks++; if (dmem[4] !== 32'hAB22_3344) begin errors++;
            $display("FAIL sb_mem got %h exp ab223344", dmem[4]); end
    endtask

    task automatic test_sh_sw();
        int lat, wc, wcyc; logic [31:0] rd, wds; logic er;
        do_req(SW, 32'h10, 32'h1122_3344, lat, rd, er, wc, wds, wcyc);
        do_req(SH, 32'h10, 32'h0000_BEEF, lat, rd, er, wc, wds, wcyc);
        checks++; if (wds !== 32'h1122_BEEF || wc != 1) begin errors++;
            $display("FAIL sh_wd got %h/%0d exp 1122beef/1", wds, wc); end
        checks++; if (lat != 3) begin errors++;
            $display("FAIL sh_latency got %0d exp 3", lat); end
        do_req(SW, 32'h14, 32'hCAFE_F00D, lat, rd, er, wc, wds, wcyc);
        checks++; if (wcyc != 1 || wc != 1) begin errors++;
            $display("FAIL sw_we_cycle got %0d/%0d exp 1/1", wcyc, wc); end
        checks++; if (wds !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL sw_wd got %h exp cafef00d", wds); end
        checks++; if (lat != 2) begin errors++;
            $display("FAIL sw_latency got %0d exp 2", lat); end
        checks++; if (dmem[5] !== 32'hCAFE_F00D) begin errors++;
            $display("FAIL sw_mem got %h exp cafef00d", dmem[5]); end
    endtask

    task automatic test_reset_in_wr();
        int lat, wc, wcyc, n; logic [31:0] rd, wds; logic er;
        do_req(SW, 32'h20, 32'h5566_7788, lat, rd, er, wc, wds, wcyc);
        @(negedge ref_clk);
        req_valid = 1'b1; req_op = SB; req_addr = 32'h20; req_wdata = 32'h99;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge ref_clk);
            n++;
        end
        @(posedge ref_clk);
        #1 req_valid = 1'b0;
        @(posedge ref_clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++;
            $display("FAIL rst_wr_we got %b exp 0", mem_we); end
        @(posedge ref_clk);
        #1 reset = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_wr_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_wr_resp got %b exp 0", resp_valid); end
        repeat (3) @(negedge ref_clk);
        checks++; if (dmem[8] !== 32'h5566_7788) begin errors++;
            $display("FAIL rst_wr_mem got %h exp 55667788", dmem[8]); end
    endtask

    task automatic test_back_to_back();
        int lat, wc, wcyc; logic [31:0] rd, wds; logic er;
        int cyc, nacc, nresp;
        int acc_cyc [4];
        int resp_cyc [4];
        logic [31:0] resp_d [4];
        logic [31:0] exp [4] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
        for (int k = 0; k < 4; k++) begin
            do_req(SW, 32'h28 + 32'(4 * k), exp[k], lat, rd, er, wc, wds, wcyc);
        end
        cyc = 0; nacc = 0; nresp = 0;
        @(negedge ref_clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h28;
        while (nresp < 4 && cyc < 40) begin
            if (resp_valid && nresp < 4) begin
                resp_cyc[nresp] = cyc; resp_d[nresp] = resp_rdata; nresp++;
            end
            if (req_valid && req_ready && nacc < 4) begin
                acc_cyc[nacc] = cyc; nacc++;
            end
            @(posedge ref_clk);
            #1;
            if (nacc == 4) req_valid = 1'b0;
            else           req_addr  = 32'h28 + 32'(4 * nacc);
            @(negedge ref_clk);
            cyc++;
        end
        req_valid = 1'b0;
        checks++; if (nresp != 4 || nacc != 4) begin errors++;
            $display("FAIL b2b_count got %0d/%0d exp 4/4", nacc, nresp); end
        for (int k = 0; k < 4; k++) begin
            if (k < nresp && k < nacc) begin
                checks++; if (resp_d[k] !== exp[k]) begin errors++;
                    $display("FAIL b2b_data[%0d] got %h exp %h", k, resp_d[k], exp[k]); end
                checks++; if (resp_cyc[k] - acc_cyc[k] != 2) begin errors++;
                    $display("FAIL b2b_latency[%0d] got %0d exp 2", k,
                             resp_cyc[k] - acc_cyc[k]); end
                if (k > 0) begin
                    checks++; if (acc_cyc[k] - acc_cyc[k-1] != 3) begin errors++;
                        $display("FAIL b2b_spacing[%0d] got %0d exp 3", k,
                                 acc_cyc[k] - acc_cyc[k-1]); end
                end
            end
        end
    endtask

    task automatic test_misaligned();
        int lat, wc, wcyc; logic [31:0] rd, wds; logic er;
        do_req(SW, 32'h21, 32'h1234_5678, lat, rd, er, wc, wds, wcyc);
`ifdef MEM_ALIGN_CHK_EN
        checks++; if (er !== 1'b1) begin errors++;
            $display("FAIL mis_err got %b exp 1", er); end
        checks++; if (lat != 1) begin errors++;
            $display("FAIL mis_latency got %0d exp 1", lat); end
        checks++; if (wc != 0) begin errors++;
            $display("FAIL mis_we_count got %0d exp 0", wc); end
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL mis_rdata got %h exp 0", rd); end
        checks++; if (dmem[8] !== 32'h5566_7788) begin errors++;
            $display("FAIL mis_mem got %h exp 55667788", dmem[8]); end
`else
        checks++; if (er !== 1'b0) begin errors++;
            $display("FAIL mis_err got %b exp 0", er); end
        checks++; if (lat != 2) begin errors++;
            $display("FAIL mis_latency got %0d exp 2", lat); end
        checks++; if (wc != 1) begin errors++;
            $display("FAIL mis_we_count got %0d exp 1", wc); end
        checks++; if (dmem[8] !== 32'h1234_5678) begin errors++;
            $display("FAIL mis_mem got %h exp 12345678", dmem[8]); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_sb_rmw();
        test_sh_sw();
        test_reset_in_wr();
        test_back_to_back();
        test_misaligned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
